// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// Handshake: a requester raises mN_req with its fields stable and holds them until mN_gnt is seen high.
interface dm_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wd;
  logic [1:0]  m0_width;
  logic        m0_sign;
  logic [31:0] m0_pc;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wd;
  logic [1:0]  m1_width;
  logic        m1_sign;
  logic [31:0] m1_pc;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [1:0]  dm_width;
  logic        dm_sign;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd, m0_width, m0_sign, m0_pc,
    input  m1_req, m1_we, m1_addr, m1_wd, m1_width, m1_sign, m1_pc,
    input  dm_rd,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output dm_we, dm_addr, dm_wd, dm_width, dm_sign, dm_pc
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wd, m0_width, m0_sign, m0_pc,
    output m1_req, m1_we, m1_addr, m1_wd, m1_width, m1_sign, m1_pc,
    output dm_rd,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  dm_we, dm_addr, dm_wd, dm_width, dm_sign, dm_pc
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory: M-stage (port 0) and debug/DMA loader (port 1).
// One access per cycle; load data and alignment errors come back registered one cycle after the grant.
module dm_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 4
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic        r_rr_last;
  logic [3:0]  r_wait_cnt;
  logic        r_rvalid0, r_rvalid1;
  logic        r_err0, r_err1;
  logic [31:0] r_rdata0, r_rdata1;

  logic        w_gnt0, w_gnt1, w_any;
  logic        w_we;
  logic [31:0] w_addr, w_wd, w_pc;
  logic [1:0]  w_width;
  logic        w_sign;
  logic        w_fault, w_load_ok;

  // Grants are gated by reset so the memory sees no access while reset is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (bus.m0_req && bus.m1_req) begin
        if (PRIO_MODE == 0) begin
          if (r_wait_cnt == MAX_W) w_gnt1 = 1'b1;
          else                     w_gnt0 = 1'b1;
        end else begin
          if (r_rr_last) w_gnt0 = 1'b1;
          else           w_gnt1 = 1'b1;
        end
      end else begin
        w_gnt0 = bus.m0_req;
        w_gnt1 = bus.m1_req;
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = 32'h0;
    w_wd    = 32'h0;
    w_width = 2'd0;
    w_sign  = 1'b0;
    w_pc    = 32'h0;
    if (w_gnt0) begin
      w_we    = bus.m0_we;
      w_addr  = bus.m0_addr;
      w_wd    = bus.m0_wd;
      w_width = bus.m0_width;
      w_sign  = bus.m0_sign;
      w_pc    = bus.m0_pc;
    end else if (w_gnt1) begin
      w_we    = bus.m1_we;
      w_addr  = bus.m1_addr;
      w_wd    = bus.m1_wd;
      w_width = bus.m1_width;
      w_sign  = bus.m1_sign;
      w_pc    = bus.m1_pc;
    end
  end

  assign w_any     = w_gnt0 | w_gnt1;
  assign w_fault   = w_any && ((w_width == 2'd3) ||
                               (w_width == 2'd0 && w_addr[1:0] != 2'b00) ||
                               (w_width == 2'd1 && w_addr[0]));
  assign w_load_ok = w_any & ~w_we & ~w_fault;

  assign bus.dm_we     = w_we & ~w_fault;
  assign bus.dm_addr   = w_addr;
  assign bus.dm_wd     = w_wd;
  assign bus.dm_width  = w_width;
  assign bus.dm_sign   = w_sign;
  assign bus.dm_pc     = w_pc;

  assign bus.m0_gnt    = w_gnt0;
  assign bus.m1_gnt    = w_gnt1;
  assign bus.m0_rvalid = r_rvalid0;
  assign bus.m1_rvalid = r_rvalid1;
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rdata  = r_rdata1;
  assign bus.m0_err    = r_err0;
  assign bus.m1_err    = r_err1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_last  <= 1'b1;
      r_wait_cnt <= 4'd0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_rdata0   <= 32'h0;
      r_rdata1   <= 32'h0;
    end else begin
      r_rvalid0 <= w_gnt0 & w_load_ok;
      r_rvalid1 <= w_gnt1 & w_load_ok;
      r_err0    <= w_gnt0 & w_fault;
      r_err1    <= w_gnt1 & w_fault;
      if (w_gnt0 & w_load_ok) r_rdata0 <= bus.dm_rd;
      if (w_gnt1 & w_load_ok) r_rdata1 <= bus.dm_rd;
      if (w_any) r_rr_last <= w_gnt1;
      // Port 1 starvation guard; only meaningful under fixed priority.
      if (PRIO_MODE == 0) begin
        if (!bus.m1_req || w_gnt1)  r_wait_cnt <= 4'd0;
        else if (r_wait_cnt != MAX_W) r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a fixed-priority instance with a byte-addressed memory model,
// and a round-robin instance with an address-derived read pattern.
module tb_dm_arbiter;

  typedef struct packed {
    logic        r;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
    logic        s;
  } req_t;

  typedef struct packed {
    req_t        p0;
    req_t        p1;
    logic        eg0;
    logic        eg1;
    logic        ewe;
    logic        erv0;
    logic        erv1;
    logic        eerr0;
    logic        eerr1;
    logic [31:0] erd0;
    logic [31:0] erd1;
  } vec_t;

  localparam logic [31:0] PC0 = 32'h0000_0100;
  localparam logic [31:0] PC1 = 32'h0000_0200;
  localparam int          NV  = 26;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dm_arbiter_if ifa ();
  dm_arbiter_if ifb ();

  dm_arbiter #(.PRIO_MODE(0), .MAX_WAIT(4)) u_dut_fp (.clk(clk), .reset(reset), .bus(ifa));
  dm_arbiter #(.PRIO_MODE(1), .MAX_WAIT(4)) u_dut_rr (.clk(clk), .reset(reset), .bus(ifb));

  // Memory model for the fixed-priority instance: word array, little-endian sub-word access.
  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic [31:0] mem_word;
  logic [15:0] mem_half;
  logic [7:0]  mem_byte;

  always_comb begin
    mem_word = mem[ifa.dm_addr[7:2]];
    mem_half = ifa.dm_addr[1] ? mem_word[31:16] : mem_word[15:0];
    mem_byte = 8'(mem_word >> {ifa.dm_addr[1:0], 3'b000});
    case (ifa.dm_width)
      2'd1:    ifa.dm_rd = ifa.dm_sign ? {{16{mem_half[15]}}, mem_half} : {16'h0, mem_half};
      2'd2:    ifa.dm_rd = ifa.dm_sign ? {{24{mem_byte[7]}}, mem_byte} : {24'h0, mem_byte};
      default: ifa.dm_rd = mem_word;
    endcase
  end

  always @(posedge clk) begin
    if (ifa.dm_we) begin
      case (ifa.dm_width)
        2'd0: mem[ifa.dm_addr[7:2]] <= ifa.dm_wd;
        2'd1: begin
          if (ifa.dm_addr[1]) mem[ifa.dm_addr[7:2]][31:16] <= ifa.dm_wd[15:0];
          else                mem[ifa.dm_addr[7:2]][15:0]  <= ifa.dm_wd[15:0];
        end
        2'd2: mem[ifa.dm_addr[7:2]][8*ifa.dm_addr[1:0] +: 8] <= ifa.dm_wd[7:0];
        default: ;
      endcase
    end
  end

  assign ifb.dm_rd = ifb.dm_addr ^ 32'h5A5A_5A5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic req_t rq(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] w, input logic s);
    return '{r: 1'b1, we: we, a: a, d: d, w: w, s: s};
  endfunction

  // g = {gnt0, gnt1, dm_we}; rs = {rvalid0, rvalid1, err0, err1}
  function automatic vec_t row(input req_t p0, input req_t p1, input logic [2:0] g,
                               input logic [3:0] rs, input logic [31:0] rd0, input logic [31:0] rd1);
    return '{p0: p0, p1: p1, eg0: g[2], eg1: g[1], ewe: g[0],
             erv0: rs[3], erv1: rs[2], eerr0: rs[1], eerr1: rs[0], erd0: rd0, erd1: rd1};
  endfunction

  task automatic drive_a(input req_t p0, input req_t p1);
    ifa.m0_req = p0.r; ifa.m0_we = p0.we; ifa.m0_addr = p0.a; ifa.m0_wd = p0.d;
    ifa.m0_width = p0.w; ifa.m0_sign = p0.s; ifa.m0_pc = PC0;
    ifa.m1_req = p1.r; ifa.m1_we = p1.we; ifa.m1_addr = p1.a; ifa.m1_wd = p1.d;
    ifa.m1_width = p1.w; ifa.m1_sign = p1.s; ifa.m1_pc = PC1;
  endtask

  task automatic drive_b(input req_t p0, input req_t p1);
    ifb.m0_req = p0.r; ifb.m0_we = p0.we; ifb.m0_addr = p0.a; ifb.m0_wd = p0.d;
    ifb.m0_width = p0.w; ifb.m0_sign = p0.s; ifb.m0_pc = PC0;
    ifb.m1_req = p1.r; ifb.m1_we = p1.we; ifb.m1_addr = p1.a; ifb.m1_wd = p1.d;
    ifb.m1_width = p1.w; ifb.m1_sign = p1.s; ifb.m1_pc = PC1;
  endtask

  vec_t vecs [NV];
  req_t idle_r, st0, st1, gsel;
  logic [31:0] epc;
  logic [31:0] r0v, r1v;
  logic        rr_pat [4];

  initial begin
    idle_r = '0;
    st0 = rq(1'b1, 32'h30, 32'hA0A0_A0A0, 2'd0, 1'b0);
    st1 = rq(1'b1, 32'h34, 32'hB1B1_B1B1, 2'd0, 1'b0);
    r0v = 32'hFFFF_80FF;
    r1v = 32'h0000_0080;

    vecs[0]  = row(rq(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd0, 1'b0), idle_r, 3'b101, 4'b0000, 32'h0, 32'h0);
    vecs[1]  = row(rq(1'b0, 32'h10, 32'h0, 2'd0, 1'b0), idle_r, 3'b100, 4'b0000, 32'h0, 32'h0);
    vecs[2]  = row(idle_r, idle_r, 3'b000, 4'b1000, 32'hDEAD_BEEF, 32'h0);
    vecs[3]  = row(idle_r, rq(1'b1, 32'h10, 32'h80FF_0000, 2'd0, 1'b0), 3'b011, 4'b0000, 32'hDEAD_BEEF, 32'h0);
    vecs[4]  = row(idle_r, rq(1'b0, 32'h13, 32'h0, 2'd2, 1'b1), 3'b010, 4'b0000, 32'hDEAD_BEEF, 32'h0);
    vecs[5]  = row(idle_r, rq(1'b0, 32'h13, 32'h0, 2'd2, 1'b0), 3'b010, 4'b0100, 32'hDEAD_BEEF, 32'hFFFF_FF80);
    vecs[6]  = row(idle_r, idle_r, 3'b000, 4'b0100, 32'hDEAD_BEEF, r1v);
    vecs[7]  = row(rq(1'b1, 32'h22, 32'h1234_5678, 2'd0, 1'b0), idle_r, 3'b100, 4'b0000, 32'hDEAD_BEEF, r1v);
    vecs[8]  = row(rq(1'b0, 32'h20, 32'h0, 2'd3, 1'b0), idle_r, 3'b100, 4'b0010, 32'hDEAD_BEEF, r1v);
    vecs[9]  = row(idle_r, idle_r, 3'b000, 4'b0010, 32'hDEAD_BEEF, r1v);
    vecs[10] = row(rq(1'b0, 32'h12, 32'h0, 2'd1, 1'b1), idle_r, 3'b100, 4'b0000, 32'hDEAD_BEEF, r1v);
    vecs[11] = row(idle_r, rq(1'b0, 32'h11, 32'h0, 2'd1, 1'b0), 3'b010, 4'b1000, r0v, r1v);
    vecs[12] = row(idle_r, idle_r, 3'b000, 4'b0001, r0v, r1v);
    for (int i = 13; i <= 16; i++) vecs[i] = row(st0, st1, 3'b101, 4'b0000, r0v, r1v);
    vecs[17] = row(st0, st1, 3'b011, 4'b0000, r0v, r1v);
    vecs[18] = row(st0, st1, 3'b101, 4'b0000, r0v, r1v);
    vecs[19] = row(st0, idle_r, 3'b101, 4'b0000, r0v, r1v);
    for (int i = 20; i <= 23; i++) vecs[i] = row(st0, st1, 3'b101, 4'b0000, r0v, r1v);
    vecs[24] = row(st0, st1, 3'b011, 4'b0000, r0v, r1v);
    vecs[25] = row(idle_r, idle_r, 3'b000, 4'b0000, r0v, r1v);

    // Reset held with a pending request: nothing granted, all registered outputs clear.
    reset = 1'b0;
    drive_a(rq(1'b1, 32'h10, 32'h1111_1111, 2'd0, 1'b0), idle_r);
    drive_b(rq(1'b0, 32'h40, 32'h0, 2'd0, 1'b0), idle_r);
    #2;
    check("rst gnt0", {31'h0, ifa.m0_gnt}, 32'h0);
    check("rst dm_we", {31'h0, ifa.dm_we}, 32'h0);
    check("rst dm_addr", ifa.dm_addr, 32'h0);
    check("rst rvalid0", {31'h0, ifa.m0_rvalid}, 32'h0);
    check("rst err0", {31'h0, ifa.m0_err}, 32'h0);
    check("rst rdata0", ifa.m0_rdata, 32'h0);
    check("rst rr gnt0", {31'h0, ifb.m0_gnt}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    drive_a(idle_r, idle_r);
    drive_b(idle_r, idle_r);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_a(vecs[i].p0, vecs[i].p1);
      #2;
      gsel = vecs[i].eg0 ? vecs[i].p0 : (vecs[i].eg1 ? vecs[i].p1 : idle_r);
      epc  = vecs[i].eg0 ? PC0 : (vecs[i].eg1 ? PC1 : 32'h0);
      check($sformatf("row%0d gnt0", i), {31'h0, ifa.m0_gnt}, {31'h0, vecs[i].eg0});
      check($sformatf("row%0d gnt1", i), {31'h0, ifa.m1_gnt}, {31'h0, vecs[i].eg1});
      check($sformatf("row%0d dm_we", i), {31'h0, ifa.dm_we}, {31'h0, vecs[i].ewe});
      check($sformatf("row%0d dm_addr", i), ifa.dm_addr, gsel.a);
      check($sformatf("row%0d dm_wd", i), ifa.dm_wd, gsel.d);
      check($sformatf("row%0d dm_width", i), {30'h0, ifa.dm_width}, {30'h0, gsel.w});
      check($sformatf("row%0d dm_sign", i), {31'h0, ifa.dm_sign}, {31'h0, gsel.s});
      check($sformatf("row%0d dm_pc", i), ifa.dm_pc, epc);
      check($sformatf("row%0d rvalid0", i), {31'h0, ifa.m0_rvalid}, {31'h0, vecs[i].erv0});
      check($sformatf("row%0d rvalid1", i), {31'h0, ifa.m1_rvalid}, {31'h0, vecs[i].erv1});
      check($sformatf("row%0d err0", i), {31'h0, ifa.m0_err}, {31'h0, vecs[i].eerr0});
      check($sformatf("row%0d err1", i), {31'h0, ifa.m1_err}, {31'h0, vecs[i].eerr1});
      check($sformatf("row%0d rdata0", i), ifa.m0_rdata, vecs[i].erd0);
      check($sformatf("row%0d rdata1", i), ifa.m1_rdata, vecs[i].erd1);
    end

    check("mem 0x20 untouched", mem[8], 32'h0);
    check("mem 0x30 store", mem[12], 32'hA0A0_A0A0);
    check("mem 0x34 store", mem[13], 32'hB1B1_B1B1);

    // Round-robin instance: both requesting from reset alternates starting with port 0.
    rr_pat[0] = 1'b0; rr_pat[1] = 1'b1; rr_pat[2] = 1'b0; rr_pat[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_b(rq(1'b0, 32'h40, 32'h0, 2'd0, 1'b0), rq(1'b0, 32'h44, 32'h0, 2'd0, 1'b0));
      #2;
      check($sformatf("rr%0d gnt0", k), {31'h0, ifb.m0_gnt}, {31'h0, ~rr_pat[k]});
      check($sformatf("rr%0d gnt1", k), {31'h0, ifb.m1_gnt}, {31'h0, rr_pat[k]});
    end
    @(negedge clk);
    drive_b(idle_r, idle_r);
    #2;
    check("rr rvalid1", {31'h0, ifb.m1_rvalid}, 32'h1);
    check("rr rvalid0", {31'h0, ifb.m0_rvalid}, 32'h0);
    check("rr rdata1", ifb.m1_rdata, 32'h5A5A_5A1E);
    check("rr rdata0", ifb.m0_rdata, 32'h5A5A_5A1A);
    @(negedge clk);
    drive_b(idle_r, rq(1'b0, 32'h48, 32'h0, 2'd0, 1'b0));
    #2;
    check("rr m1 alone gnt1", {31'h0, ifb.m1_gnt}, 32'h1);
    @(negedge clk);
    drive_b(rq(1'b0, 32'h4C, 32'h0, 2'd0, 1'b0), idle_r);
    #2;
    check("rr m0 alone gnt0", {31'h0, ifb.m0_gnt}, 32'h1);

    // Reset asserted just after an m0 load grant: the pending rvalid is discarded.
    @(negedge clk);
    drive_b(idle_r, idle_r);
    drive_a(rq(1'b0, 32'h10, 32'h0, 2'd0, 1'b0), idle_r);
    #2;
    check("mid gnt0 before reset", {31'h0, ifa.m0_gnt}, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid async gnt0", {31'h0, ifa.m0_gnt}, 32'h0);
    check("mid async rvalid0", {31'h0, ifa.m0_rvalid}, 32'h0);
    check("mid async rdata0", ifa.m0_rdata, 32'h0);
    @(negedge clk);
    #2;
    check("mid dm_we", {31'h0, ifa.dm_we}, 32'h0);
    check("mid dm_addr", ifa.dm_addr, 32'h0);
    check("mid rvalid0", {31'h0, ifa.m0_rvalid}, 32'h0);
    check("mid rdata1", ifa.m1_rdata, 32'h0);
    check("mid err0", {31'h0, ifa.m0_err}, 32'h0);
    @(negedge clk);
    drive_a(idle_r, idle_r);
    reset = 1'b1;
    #2;
    check("post rvalid0", {31'h0, ifa.m0_rvalid}, 32'h0);
    @(negedge clk);
    #2;
    check("post rvalid0 later", {31'h0, ifa.m0_rvalid}, 32'h0);

    // After reset the round-robin pointer again favours port 0.
    drive_b(rq(1'b0, 32'h40, 32'h0, 2'd0, 1'b0), rq(1'b0, 32'h44, 32'h0, 2'd0, 1'b0));
    #1;
    check("rr after reset gnt0", {31'h0, ifb.m0_gnt}, 32'h1);
    check("rr after reset gnt1", {31'h0, ifb.m1_gnt}, 32'h0);
    @(negedge clk);
    drive_b(idle_r, idle_r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
